// File: rtl/sram_req_arbiter.sv
// Round-robin arbiter sharing one serial SRAM port (chip-select + SPI frame) among NREQ requesters.
// Optional watchdog on the CS/SPI wait states is enabled by defining SRAM_ARB_TIMEOUT_EN.
module sram_req_arbiter #(
    parameter int NREQ    = 3,
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 16,
    parameter int FRAME_W = 8 + ADDR_W + DATA_W,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        req_we,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_wdata,
    output logic [NREQ-1:0]        ack,
    output logic [DATA_W-1:0]      rdata,
    output logic                   busy,
    output logic                   cs_en,
    input  logic                   cs_done,
    input  logic                   spi_done,
    output logic [FRAME_W-1:0]     tx,
    input  logic [FRAME_W-1:0]     rx,
    output logic                   err
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        WAIT_CS  = 3'd2,
        WAIT_SPI = 3'd3,
        ACK      = 3'd4
    } state_t;

    state_t state_reg, state_next;

    logic [IDX_W-1:0]  rr_reg;
    logic [IDX_W-1:0]  grant_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] rdata_reg;

    logic [ADDR_W-1:0] addr_arr  [NREQ];
    logic [DATA_W-1:0] wdata_arr [NREQ];
    logic [NREQ-1:0]   grant_onehot;
    logic [IDX_W-1:0]  win_idx;
    logic              win_found;
    logic [FRAME_W-1:0] frame;
    logic              timeout_fire;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign addr_arr[gi]     = req_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi]    = req_wdata[gi*DATA_W +: DATA_W];
            assign grant_onehot[gi] = (grant_reg == IDX_W'(gi));
        end
    endgenerate

    // Search starts just after the last winner, so the previous grantee is lowest priority.
    always_comb begin
        int cand;
        cand      = 0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(rr_reg) + k) % NREQ;
            if (!win_found && req[IDX_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

    assign frame = we_reg ? {8'h02, addr_reg, wdata_reg}
                          : {8'h03, addr_reg, {DATA_W{1'b0}}};

`ifdef SRAM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             err_reg;

    // A spi_done arriving in the same cycle as the limit still counts as a normal completion.
    assign timeout_fire = ((state_reg == WAIT_CS) || (state_reg == WAIT_SPI && !spi_done))
                          && (cnt_reg == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_reg <= '0;
            err_reg <= 1'b0;
        end else begin
            if (state_reg == START)
                cnt_reg <= '0;
            else if (state_reg == WAIT_CS || state_reg == WAIT_SPI)
                cnt_reg <= cnt_reg + 1'b1;
            if (timeout_fire)
                err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`else
    assign timeout_fire = 1'b0;
    assign err          = 1'b0;
`endif

    // Upper frame bits carry opcode/address echo and are not needed.
    logic unused_bits;
    assign unused_bits = &{1'b0, rx[FRAME_W-1:DATA_W], (TIMEOUT > 0)};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (win_found) state_next = START;
            START:    state_next = WAIT_CS;
            WAIT_CS: begin
                if (timeout_fire)
                    state_next = ACK;
                else if (cs_done)
                    state_next = WAIT_SPI;
            end
            WAIT_SPI: if (spi_done || timeout_fire) state_next = ACK;
            ACK:      state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_reg != IDLE);
        cs_en = (state_reg == START);
        tx    = '0;
        ack   = '0;
        case (state_reg)
            START, WAIT_CS, WAIT_SPI: tx  = frame;
            ACK:                      ack = grant_onehot;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rr_reg    <= IDX_W'(NREQ - 1);
            grant_reg <= '0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
        end else begin
            if (state_reg == IDLE && win_found) begin
                grant_reg <= win_idx;
                we_reg    <= req_we[win_idx];
                addr_reg  <= addr_arr[win_idx];
                wdata_reg <= wdata_arr[win_idx];
            end
            if (state_reg == WAIT_SPI && spi_done && !we_reg)
                rdata_reg <= rx[DATA_W-1:0];
            else if (timeout_fire && !we_reg)
                rdata_reg <= '0;
            if (state_reg == ACK)
                rr_reg <= grant_reg;
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Scoreboard bench for sram_req_arbiter: a CS/SPI responder model plus per-scenario tasks.
// Defining SRAM_ARB_TIMEOUT_EN for both DUT and bench adds the watchdog scenario.
module tb_sram_req_arbiter;

    logic        clk;
    logic        nrst;
    logic [2:0]  req;
    logic [2:0]  req_we;
    logic [71:0] req_addr;
    logic [47:0] req_wdata;
    logic [2:0]  ack;
    logic [15:0] rdata;
    logic        busy;
    logic        cs_en;
    logic        cs_done;
    logic        spi_done;
    logic [47:0] tx;
    logic [47:0] rx;
    logic        err;

    typedef struct packed {
        logic [2:0]  ack;
        logic [15:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          cs_cnt = 0;
    logic        resp_no_spi = 1'b0;
    logic [15:0] resp_data = 16'h0000;

    sram_req_arbiter #(
        .NREQ(3), .ADDR_W(24), .DATA_W(16), .FRAME_W(48), .TIMEOUT(16)
    ) dut (
        .clk(clk), .nrst(nrst), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack), .rdata(rdata),
        .busy(busy), .cs_en(cs_en), .cs_done(cs_done), .spi_done(spi_done),
        .tx(tx), .rx(rx), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CS/SPI model: cs_done two cycles after cs_en, spi_done two cycles after that.
    initial begin
        cs_done  = 1'b0;
        spi_done = 1'b0;
        rx       = '0;
        forever begin
            @(negedge clk);
            cs_done  = 1'b0;
            spi_done = 1'b0;
            if (cs_en === 1'b1) begin
                @(negedge clk);
                @(negedge clk);
                cs_done = 1'b1;
                @(negedge clk);
                cs_done = 1'b0;
                if (!resp_no_spi) begin
                    @(negedge clk);
                    rx       = {32'h0, resp_data};
                    spi_done = 1'b1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cs_en === 1'b1) cs_cnt++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, total=%0d", total);
        $fatal(1);
    end

    task automatic wait_ack(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ack !== 3'b000) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_cs_en(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cs_en === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({ack, rdata, busy, cs_en, tx, err} !== '0) begin
            bad++;
            $display("FAIL reset_values: ack=%b rdata=%h busy=%b cs_en=%b tx=%h err=%b want all 0",
                     ack, rdata, busy, cs_en, tx, err);
        end
        nrst = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_busy: busy=%b want 0", busy);
        end
    endtask

    task automatic test_single_write();
        logic ok;
        exp_t e;
        exp_q.delete();
        exp_q.push_back('{ack: 3'b001, rdata: 16'h0000});
        req_we          = 3'b001;
        req_addr[23:0]  = 24'h000010;
        req_wdata[15:0] = 16'hA5A5;
        resp_data       = 16'hBEEF;
        req             = 3'b001;
        @(negedge clk);
        total++;
        if (cs_en !== 1'b1) begin
            bad++;
            $display("FAIL write_cs_latency: cs_en=%b want 1", cs_en);
        end
        total++;
        if (tx !== 48'h02_000010_A5A5) begin
            bad++;
            $display("FAIL write_tx: tx=%h want 02000010a5a5", tx);
        end
        req_addr[23:0]  = 24'hFFFFFF;
        req_wdata[15:0] = 16'h0000;
        @(negedge clk);
        total++;
        if (cs_en !== 1'b0 || tx !== 48'h02_000010_A5A5) begin
            bad++;
            $display("FAIL write_tx_hold: cs_en=%b tx=%h want 0 02000010a5a5", cs_en, tx);
        end
        wait_ack(40, ok);
        total++;
        if (!ok || exp_q.size() == 0) begin
            bad++;
            $display("FAIL write_ack: no ack (ack=%b) want 001", ack);
        end else begin
            e = exp_q.pop_front();
            if (ack !== e.ack || rdata !== e.rdata || tx !== 48'h0) begin
                bad++;
                $display("FAIL write_ack: ack=%b rdata=%h tx=%h want ack=%b rdata=%h tx=0",
                         ack, rdata, tx, e.ack, e.rdata);
            end
        end
        $display("write txn: ack=%b rdata=%h", ack, rdata);
        req = 3'b000;
        @(negedge clk);
        total++;
        if (ack !== 3'b000) begin
            bad++;
            $display("FAIL write_ack_pulse: ack=%b want 000", ack);
        end
    endtask

    task automatic test_single_read();
        logic ok;
        exp_t e;
        exp_q.delete();
        exp_q.push_back('{ack: 3'b010, rdata: 16'h1234});
        req_we           = 3'b001;
        req_addr[47:24]  = 24'h01001C;
        req_wdata[31:16] = 16'hFFFF;
        resp_data        = 16'h1234;
        req              = 3'b010;
        @(negedge clk);
        total++;
        if (cs_en !== 1'b1 || tx !== 48'h03_01001C_0000) begin
            bad++;
            $display("FAIL read_tx: cs_en=%b tx=%h want 1 0301001c0000", cs_en, tx);
        end
        wait_ack(40, ok);
        total++;
        if (!ok || exp_q.size() == 0) begin
            bad++;
            $display("FAIL read_ack: no ack (ack=%b) want 010", ack);
        end else begin
            e = exp_q.pop_front();
            if (ack !== e.ack || rdata !== e.rdata) begin
                bad++;
                $display("FAIL read_ack: ack=%b rdata=%h want ack=%b rdata=%h",
                         ack, rdata, e.ack, e.rdata);
            end
        end
        $display("read txn: ack=%b rdata=%h", ack, rdata);
        req = 3'b000;
        @(negedge clk);
    endtask

    // Re-reset with a fixed request pattern, then check grant order from the scoreboard.
    task automatic run_rr(input string name, input logic [2:0] pattern, input int n,
                          input logic check_gap);
        logic ok;
        exp_t e;
        int   cs0;
        nrst      = 1'b0;
        req_we    = 3'b000;
        resp_data = 16'h0042;
        req       = pattern;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        cs0  = cs_cnt;
        for (int k = 0; k < n; k++) begin
            wait_ack(40, ok);
            total++;
            if (!ok || exp_q.size() == 0) begin
                bad++;
                $display("FAIL %s_ack%0d: no ack (ack=%b)", name, k, ack);
            end else begin
                e = exp_q.pop_front();
                if (ack !== e.ack || rdata !== e.rdata) begin
                    bad++;
                    $display("FAIL %s_ack%0d: ack=%b rdata=%h want ack=%b rdata=%h",
                             name, k, ack, rdata, e.ack, e.rdata);
                end
            end
            $display("%s txn %0d: ack=%b rdata=%h", name, k, ack, rdata);
            if (k == n - 1) begin
                req = 3'b000;
            end else if (check_gap) begin
                @(negedge clk);
                @(negedge clk);
                total++;
                if (cs_en !== 1'b1) begin
                    bad++;
                    $display("FAIL %s_gap%0d: cs_en=%b two cycles after ack, want 1", name, k, cs_en);
                end
            end
        end
        repeat (3) @(negedge clk);
        total++;
        if (cs_cnt - cs0 != n) begin
            bad++;
            $display("FAIL %s_cs_count: cs_en pulses=%0d want %0d", name, cs_cnt - cs0, n);
        end
    endtask

    task automatic test_contention();
        exp_q.delete();
        exp_q.push_back('{ack: 3'b001, rdata: 16'h0042});
        exp_q.push_back('{ack: 3'b010, rdata: 16'h0042});
        exp_q.push_back('{ack: 3'b100, rdata: 16'h0042});
        exp_q.push_back('{ack: 3'b001, rdata: 16'h0042});
        run_rr("contention", 3'b111, 4, 1'b1);
    endtask

    task automatic test_fairness();
        exp_q.delete();
        exp_q.push_back('{ack: 3'b001, rdata: 16'h0042});
        exp_q.push_back('{ack: 3'b100, rdata: 16'h0042});
        exp_q.push_back('{ack: 3'b001, rdata: 16'h0042});
        exp_q.push_back('{ack: 3'b100, rdata: 16'h0042});
        run_rr("fairness", 3'b101, 4, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic ok;
        exp_t e;
        exp_q.delete();
        // Grant requester 0 first so the pointer would favour requester 1 if reset missed it.
        exp_q.push_back('{ack: 3'b001, rdata: 16'h1111});
        req_we    = 3'b000;
        resp_data = 16'h1111;
        req       = 3'b001;
        wait_ack(40, ok);
        total++;
        if (!ok || exp_q.size() == 0) begin
            bad++;
            $display("FAIL midrst_pre_ack: no ack (ack=%b)", ack);
        end else begin
            e = exp_q.pop_front();
            if (ack !== e.ack || rdata !== e.rdata) begin
                bad++;
                $display("FAIL midrst_pre_ack: ack=%b rdata=%h want ack=%b rdata=%h",
                         ack, rdata, e.ack, e.rdata);
            end
        end
        req = 3'b000;
        @(negedge clk);
        resp_no_spi = 1'b1;
        req         = 3'b011;
        wait_cs_en(20, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL midrst_cs_en: cs_en=%b never seen, want 1", cs_en);
        end
        repeat (4) @(negedge clk);
        nrst = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || tx !== 48'h0 || cs_en !== 1'b0 || ack !== 3'b000) begin
            bad++;
            $display("FAIL midrst_async: busy=%b tx=%h cs_en=%b ack=%b want all 0",
                     busy, tx, cs_en, ack);
        end
        repeat (2) @(negedge clk);
        resp_no_spi = 1'b0;
        resp_data   = 16'h5A5A;
        exp_q.push_back('{ack: 3'b001, rdata: 16'h5A5A});
        exp_q.push_back('{ack: 3'b010, rdata: 16'h5A5A});
        nrst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_ack(40, ok);
            total++;
            if (!ok || exp_q.size() == 0) begin
                bad++;
                $display("FAIL midrst_after%0d: no ack (ack=%b)", k, ack);
            end else begin
                e = exp_q.pop_front();
                if (ack !== e.ack || rdata !== e.rdata) begin
                    bad++;
                    $display("FAIL midrst_after%0d: ack=%b rdata=%h want ack=%b rdata=%h",
                             k, ack, rdata, e.ack, e.rdata);
                end
            end
            $display("midrst txn %0d: ack=%b rdata=%h", k, ack, rdata);
            req = req & ~ack;
        end
        req = 3'b000;
        @(negedge clk);
    endtask

`ifdef SRAM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic ok;
        exp_t e;
        exp_q.delete();
        exp_q.push_back('{ack: 3'b100, rdata: 16'h0000});
        resp_no_spi      = 1'b1;
        req_we           = 3'b000;
        req_addr[71:48]  = 24'h000100;
        req              = 3'b100;
        wait_cs_en(20, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL timeout_cs_en: cs_en never seen");
        end
        repeat (16) @(negedge clk);
        total++;
        if (ack !== 3'b000) begin
            bad++;
            $display("FAIL timeout_early: ack=%b one cycle before limit, want 000", ack);
        end
        @(negedge clk);
        e = exp_q.pop_front();
        total++;
        if (ack !== e.ack || rdata !== e.rdata || err !== 1'b1) begin
            bad++;
            $display("FAIL timeout_ack: ack=%b rdata=%h err=%b want ack=%b rdata=%h err=1",
                     ack, rdata, err, e.ack, e.rdata);
        end
        $display("timeout txn: ack=%b rdata=%h err=%b", ack, rdata, err);
        req         = 3'b000;
        resp_no_spi = 1'b0;
        req_we      = 3'b001;
        req         = 3'b001;
        wait_ack(40, ok);
        req = 3'b000;
        total++;
        if (!ok || ack !== 3'b001 || err !== 1'b1) begin
            bad++;
            $display("FAIL timeout_sticky: ack=%b err=%b want ack=001 err=1", ack, err);
        end
        @(negedge clk);
    endtask
`else
    task automatic test_timeout();
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL err_tied: err=%b want 0", err);
        end
    endtask
`endif

    initial begin
        nrst      = 1'b0;
        req       = 3'b000;
        req_we    = 3'b000;
        req_addr  = '0;
        req_wdata = '0;
        test_reset();
        test_single_write();
        test_single_read();
        test_contention();
        test_fairness();
        test_reset_mid();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
